// File: rtl/psum_ofifo_pkg.sv
// Shared sizing helpers for the psum output collector.
package psum_ofifo_pkg;

    localparam int unsigned DEFAULT_DEPTH = 64;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned PTR_W = ptr_width(DEFAULT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

endpackage

// File: rtl/psum_ofifo_col.sv
// Single-column circular FIFO with first-word-fall-through head and drop detect.
module psum_ofifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [psum_bw-1:0] din,
    input  logic               rd_en,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int unsigned PW = ptr_width(depth);
    localparam int unsigned CW = PW + 1;

    logic [psum_bw-1:0] mem [depth];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               do_wr;
    logic               do_rd;

    // Flags come only from the registered count; a pop frees the slot for a same-cycle write.
    assign empty = (count == '0);
    assign full  = (count == CW'(depth));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && full && !do_rd;
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PW'(1);
            if (do_rd) rptr <= rptr + PW'(1);
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// South-edge psum collector: per-column FIFOs realigned into row-wide words.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [col*psum_bw-1:0] head;
    logic                   rd_en;

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = &(~full);
    assign rd_en   = rd && o_valid;
    assign out     = o_valid ? head : '0;

    for (genvar c = 0; c < int'(col); c++) begin : g_col
        psum_ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr[c]),
            .din   (in[c*psum_bw +: psum_bw]),
            .rd_en (rd_en),
            .dout  (head[c*psum_bw +: psum_bw]),
            .empty (empty[c]),
            .full  (full[c]),
            .drop  (drop[c])
        );
    end

    // Sticky record of any dropped write; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo.
module tb_psum_ofifo;

    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned W     = COL * BW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [COL-1:0] wr = '0;
    logic           rd = 1'b0;
    logic [W-1:0]   out_data;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_data),
        .wr       (wr),
        .rd       (rd),
        .out      (out_data),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = '0;
        rd = 1'b0;
        in_data = '0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Row word: column c holds base + c*256 + k.
    function automatic logic [W-1:0] mk_word(input logic [15:0] base, input int k);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < int'(COL); c++) w[c*BW +: BW] = base + 16'(c * 256) + 16'(k);
        return w;
    endfunction

    task automatic test_reset();
        logic [3:0] st;
        do_reset();
        st = {o_valid, o_full, o_ready, overflow};
        checks++;
        if (st !== 4'b0010) begin errors++; $display("FAIL reset_flags got %b exp 0010", st); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out_data); end
        rd = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd = 1'b0;
        st = {o_valid, o_full, o_ready, overflow};
        checks++;
        if (st !== 4'b0010) begin errors++; $display("FAIL idle_rd_flags got %b exp 0010", st); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL idle_rd_out got %h exp 0", out_data); end
    endtask

    task automatic test_skew();
        logic [W-1:0] exp;
        do_reset();
        for (int c = 0; c < int'(COL); c++) begin
            in_data = '0;
            in_data[c*BW +: BW] = 16'h0100 + 16'(c);
            wr = COL'(1) << c;
            step();
            wr = '0;
            checks++;
            if (o_valid !== (c == int'(COL) - 1)) begin
                errors++; $display("FAIL skew_valid col %0d got %b", c, o_valid);
            end
        end
        exp = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL skew_out got %h exp %h", out_data, exp); end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_pop_valid got %b exp 0", o_valid); end
    endtask

    task automatic test_fill_one();
        logic [W-1:0] exp;
        do_reset();
        wr = 8'h01;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data[15:0] = 16'h2000 + 16'(i);
            step();
        end
        wr = '0;
        checks++;
        if ({o_full, o_ready, overflow, o_valid} !== 4'b1000) begin
            errors++; $display("FAIL fill1_flags got %b exp 1000", {o_full, o_ready, overflow, o_valid});
        end
        in_data[15:0] = 16'hDEAD;
        wr = 8'h01;
        step();
        wr = '0;
        checks++;
        if ({overflow, o_full} !== 2'b11) begin
            errors++; $display("FAIL fill1_overflow got %b exp 11", {overflow, o_full});
        end
        wr = 8'hFE;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data = mk_word(16'h3000, i);
            step();
        end
        wr = '0;
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL fill1_valid got %b exp 1", o_valid); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp = mk_word(16'h3000, i);
            exp[15:0] = 16'h2000 + 16'(i);
            checks++;
            if (out_data !== exp) begin
                errors++; $display("FAIL fill1_data idx %0d got %h exp %h", i, out_data, exp);
            end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++;
        if ({o_valid, overflow} !== 2'b01) begin
            errors++; $display("FAIL fill1_drain got %b exp 01", {o_valid, overflow});
        end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] exp;
        do_reset();
        wr = 8'hFF;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data = mk_word(16'h4000, i);
            step();
        end
        checks++;
        if ({o_full, o_ready} !== 2'b10) begin
            errors++; $display("FAIL fullrw_full got %b exp 10", {o_full, o_ready});
        end
        in_data = mk_word(16'h5000, 0);
        rd = 1'b1;
        step();
        wr = '0;
        rd = 1'b0;
        checks++;
        if ({overflow, o_full} !== 2'b01) begin
            errors++; $display("FAIL fullrw_same got %b exp 01", {overflow, o_full});
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            exp = mk_word(16'h4000, i);
            checks++;
            if (out_data !== exp) begin
                errors++; $display("FAIL fullrw_data idx %0d got %h exp %h", i, out_data, exp);
            end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        exp = mk_word(16'h5000, 0);
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL fullrw_new got %h exp %h", out_data, exp); end
        checks++;
        if ({o_valid, o_full} !== 2'b10) begin
            errors++; $display("FAIL fullrw_last got %b exp 10", {o_valid, o_full});
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL fullrw_empty got %b exp 0", o_valid); end
    endtask

    task automatic test_wrap();
        int wn = 0;
        int rn = 0;
        int cyc = 0;
        do_reset();
        while (rn < 200 && cyc < 3000) begin
            rd = 1'b0;
            if (o_valid && $urandom_range(0, 3) != 0) begin
                checks++;
                if (out_data !== mk_word(16'h0000, rn)) begin
                    errors++; $display("FAIL wrap_data idx %0d got %h exp %h", rn, out_data, mk_word(16'h0000, rn));
                end
                rd = 1'b1;
                rn++;
            end
            wr = '0;
            if (wn < 200 && o_ready) begin
                in_data = mk_word(16'h0000, wn);
                wr = 8'hFF;
                wn++;
            end
            step();
            cyc++;
        end
        rd = 1'b0;
        wr = '0;
        checks++;
        if (rn != 200) begin errors++; $display("FAIL wrap_count got %0d exp 200", rn); end
        checks++;
        if ({overflow, o_valid} !== 2'b00) begin
            errors++; $display("FAIL wrap_end got %b exp 00", {overflow, o_valid});
        end
    endtask

    task automatic test_midreset();
        do_reset();
        wr = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            in_data = mk_word(16'h6000, i);
            step();
        end
        wr = '0;
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", o_valid); end
        reset = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_ready, o_full} !== 3'b010 || out_data !== '0) begin
            errors++; $display("FAIL mid_async got %b out %h exp 010 out 0", {o_valid, o_ready, o_full}, out_data);
        end
        in_data = mk_word(16'hBAD0, 0);
        wr = 8'hFF;
        rd = 1'b1;
        step();
        reset = 1'b1;
        wr = '0;
        rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_ignored got %b exp 0", o_valid); end
        wr = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            in_data = mk_word(16'h7000, i);
            step();
        end
        wr = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data !== mk_word(16'h7000, i)) begin
                errors++; $display("FAIL mid_data idx %0d got %h exp %h", i, out_data, mk_word(16'h7000, i));
            end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got %b exp 0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_fill_one();
        test_full_rw();
        test_wrap();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector at the south edge of the MAC array. It captures each column's partial sum when that column's valid strobe fires. Because columns finish on different cycles, it buffers them in per-column FIFOs and realigns them. It then presents complete row-wide words (one psum per column) to the downstream reader through a valid/read handshake.

## Interface
Parameters:
- col, 8, number of array columns
- psum_bw, 16, bits per partial sum
- depth, 64, entries per column FIFO; power of two, ≥ 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- in  input  col*psum_bw  psums from array south edge; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-column valid strobe from array; wr[c] writes column c's in slice
- rd  input  1  pop one entry from every column
- out  output  col*psum_bw  head entry of every column, same bit ordering as in
- o_valid  output  1  every column holds ≥ 1 entry
- o_full  output  1  at least one column holds depth entries
- o_ready  output  1  every column has ≥ 1 free entry
- overflow  output  1  sticky: a write was dropped

## Operation
- Each column is an independent circular FIFO with a write pointer, a read pointer and an occupancy count.
- Pointers are log2(depth) bits and wrap modulo depth. Count is log2(depth)+1 bits, range 0..depth.
- Write, column c: if wr[c]=1 and the column is not full, store in slice c at the write pointer, then increment the write pointer and the count.
- Read: rd is honoured only when o_valid=1. It pops all columns together: every read pointer increments and every count decrements.
- rd with o_valid=0 is ignored. Nothing changes and no error is flagged.
- Same column, same cycle, write and honoured read: both take effect and the count is unchanged.
  - This applies when the column is full: the write is accepted because the pop frees the slot.
  - This applies when the column is empty: the read is not honoured (o_valid=0), so only the write takes effect.
- Write to a full column with no honoured read in the same cycle: data is dropped, overflow is set to 1, and the other columns' writes proceed normally.
- overflow clears only on reset.
- out is first-word-fall-through: it shows the entry at each column's read pointer. It is forced to all-zero whenever o_valid=0.
- o_valid is the AND of the per-column non-empty flags. o_full is the OR of the per-column full flags. o_ready is the AND of the per-column not-full flags.
- No arithmetic is performed on the data; psums pass through bit-exact.

## Timing
- Reset asserted (reset=0), asynchronously:
  - all pointers and counts go to 0;
  - o_valid=0, o_full=0, o_ready=1, overflow=0, out=0;
  - memory contents are not cleared.
- Reset asserted mid-stream discards all buffered entries. Writes and reads presented in the deassertion cycle are ignored. The first edge at which reset=1 is sampled performs normal operation.
- Write latency: wr[c] sampled at edge t. The count is updated after t, so flags and out reflect the new entry from edge t onward (visible in cycle t+1).
- The reader may sample out while o_valid=1 and assert rd in the same cycle. The next word, if any, appears after that edge.
- Back-to-back reads: one word per cycle while o_valid stays 1.
- Wrap-around: after depth writes and depth reads, pointers return to 0 and ordering is preserved.
- All flags are derived combinationally from registered counts. There are no combinational paths from wr or rd to any output.

## Structure
- Package psum_ofifo_pkg:
  - a clog2-based pointer-width constant/function;
  - a localparam for count width (ptr width + 1).
- Sub-module psum_ofifo_col: one single-column FIFO holding its data array, pointers and count.
  - Inputs: wr_en, din, rd_en (rd & o_valid).
  - Outputs: dout, empty, full, drop.
- Top level:
  - instantiates col copies of psum_ofifo_col;
  - combines empty/full into o_valid, o_full and o_ready;
  - ORs the drop signals into the sticky overflow register;
  - gates out to zero when o_valid=0.

## Test plan
- Reset, then idle: o_valid=0, o_ready=1, o_full=0, overflow=0, out=0. Asserting rd for 5 cycles leaves all outputs unchanged.
- Skewed arrival: write column c with value 16'h0100+c at cycle c, c=0..7.
  - o_valid must stay 0 until column 7 is written, then rise.
  - out must read 16'h0107..16'h0100 from MSB to LSB.
  - One rd must return o_valid to 0.
- Fill one column (depth=64): 64 writes to column 0 only → o_full=1, o_ready=0. A 65th write sets overflow=1 and leaves the column 0 count at 64.
- Full with simultaneous write and read:
  - fill all columns to 64 entries;
  - assert wr=8'hFF and rd together;
  - counts stay at 64, no overflow is raised, and the new data appears after 63 further reads.
- Wrap-around ordering: stream 200 words with an incrementing pattern, writing and reading concurrently with random rd gaps. Read data must match write order exactly, with no loss and overflow=0.
- Mid-stream reset: with 10 entries buffered, pulse reset low for 1 cycle. o_valid=0 and all counts are 0 immediately. Subsequent writes are read back from index 0 correctly.
